fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch front end feeding the single-cycle `processor` core.
- Owns the architectural fetch PC, which loads from `startpc` on reset.
- Issues word requests to an instruction memory with a valid/ready handshake and variable latency, and buffers returned words in a small in-order queue.
- Delivers instructions to the core over a valid/ready handshake, with branch/jump redirect and a halt request.

Parameters:
- PC_W, 64, width of PC and memory addresses.
- INSTR_W, 32, instruction word width.
- DEPTH, 2, instruction queue entries (power of two, ≥ 2).
- MAX_OUT, 4, maximum in-flight imem requests, live plus stale.

Ports:
- Clk  in  1  clock, rising edge.
- resetl  in  1  asynchronous active-low reset.
- startpc  in  PC_W  fetch PC loaded while resetl is low.
- redirect_valid  in  1  taken branch/jump from the core.
- redirect_pc  in  PC_W  redirect target; bits [1:0] are ignored and forced to 0.
- halt_req  in  1  stop issuing new fetches.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  PC_W  word address (fetch PC).
- imem_rsp_valid  in  1  response valid; in order, no backpressure.
- imem_rsp_data  in  INSTR_W  response word.
- instr_valid  out  1  queue head valid.
- instr_ready  in  1  core consumes the head.
- instr_out  out  INSTR_W  head instruction.
- instr_pc  out  PC_W  PC of the head instruction.
- currentpc  out  PC_W  current fetch PC (next address to request).
- halted  out  1  state is HALTED.

Behaviour:
- Reset (resetl=0, asynchronous):
  - fetch_pc=startpc, with bits [1:0] forced to 0; currentpc=fetch_pc.
  - Queue emptied; live_out=0, stale_out=0, state=FETCH.
  - imem_req_valid=0, instr_valid=0, instr_out=0, instr_pc=0, halted=0.
- Reset mid-operation discards all queue contents and in-flight bookkeeping. Responses arriving after reset deassertion for pre-reset requests are the memory's responsibility; the bench must not produce them.
- Issue condition: imem_req_valid = (state==FETCH) & !redirect_valid & (occ+live_out < DEPTH) & (live_out+stale_out < MAX_OUT).
  - imem_req_addr=fetch_pc.
- Request accept (valid&ready):
  - fetch_pc += 4, modulo 2^PC_W; 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
  - live_out++.
  - The request's PC is recorded in an in-flight PC FIFO of MAX_OUT entries.
- Response:
  - If stale_out>0: drop the word, stale_out--.
  - Otherwise: push {data, pc} into the queue, live_out--.
  - Credits guarantee the queue never overflows. A response with live_out=stale_out=0 is a protocol error: the word is ignored and a sim assertion fires.
- Delivery:
  - instr_valid = occ>0; instr_out and instr_pc show the head, registered.
  - A pop occurs on instr_valid&instr_ready.
  - Zero-latency bypass from response to output is not allowed: minimum latency is imem response → instr_valid one cycle later.
- Redirect (redirect_valid=1 at the edge):
  - Queue flushed; a same-cycle pop counts as delivered.
  - stale_out += live_out, and live_out=0. A same-cycle response is resolved first by the normal rule.
  - fetch_pc=redirect_pc, with bits [1:0]=0.
  - state → FETCH, even from HALTING or HALTED.
- Redirect has priority over halt_req in the same cycle.
- FSM:
  - FETCH → HALTING on halt_req & !redirect_valid.
  - HALTING: no new requests; in-flight responses still fill the queue. → HALTED when live_out=0 and stale_out=0.
  - HALTED: halted=1; the queue still drains to the core. Exit only via redirect or reset.
  - halt_req deasserting in HALTING or HALTED does not resume fetch.
- Throughput: with a zero-latency memory and instr_ready=1, one instruction per cycle sustained for DEPTH≥2.
- Counters are sized clog2(MAX_OUT+1); the in-flight invariant live_out+stale_out ≤ MAX_OUT is asserted.

Decomposition:
- A shared package `fetch_pkg` holds:
  - the FSM state enum (FETCH, HALTING, HALTED);
  - the queue entry typedef {pc, instr};
  - the constants INSTR_BYTES=4 and PC_ALIGN_MASK.
- One sub-module: `fetch_fifo`, a parameterised synchronous FIFO with push, pop, flush, occ and async reset. It is instantiated twice: as the instruction queue (DEPTH) and as the in-flight PC FIFO (MAX_OUT).

Test Plan:
- Reset with startpc=0x40, memory latency 0, instr_ready=1. Required: imem_req_addr sequence 0x40, 0x44, 0x48…; instr_pc 0x40 one cycle after the first response; one instruction per cycle thereafter; currentpc advances by 4 per accept.
- Memory latency 3 with instr_ready held 0. Required: exactly DEPTH=2 requests accepted (0x0, 0x4); imem_req_valid stays 0 until a pop, after which the request for 0x8 issues.
- Issue 0x0 and 0x4 live, then redirect to 0x103. Required: both in-flight responses dropped (stale_out 2→0); the next request is 0x100; the first delivered instr_pc is 0x100.
- Redirect in the same cycle as a response and a pop. Required: the popped instruction is delivered once; the response word never appears on instr_out; the queue is empty afterwards.
- halt_req with 2 requests outstanding. Required: no new requests; both responses are queued; halted=1 once drained; a redirect to 0x200 resumes fetch at 0x200.
- startpc=0xFFFF_FFFF_FFFF_FFF8, latency 0. Required: requests 0x…FFF8, 0x…FFFC, 0x0, 0x4. Then assert resetl=0 mid-stream: outputs clear immediately, with no clock edge required.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch front end
package fetch_pkg;

    localparam int FETCH_PC_W    = 64;
    localparam int FETCH_INSTR_W = 32;
    localparam int INSTR_BYTES   = 4;

    localparam logic [FETCH_PC_W-1:0] PC_ALIGN_MASK = ~FETCH_PC_W'(INSTR_BYTES - 1);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HALTING = 2'd1,
        HALTED  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_PC_W-1:0]    pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, occupancy count and registered storage
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output logic [WIDTH-1:0]             o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_occ
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_occ;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign w_full    = (r_occ == CW'(DEPTH));
    assign w_empty   = (r_occ == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    // A full FIFO may still take a push when the head leaves in the same cycle.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_occ <= r_occ + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    assign o_head = r_mem[r_rd_ptr];
    assign o_occ  = r_occ;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, credit-limited imem request issue, in-order instruction queue
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 2,
    parameter int MAX_OUT = 4
) (
    input  logic               Clk,
    input  logic               resetl,
    input  logic [PC_W-1:0]    startpc,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt_req,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc,
    output logic [PC_W-1:0]    currentpc,
    output logic               halted
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + OCC_W + 1;

    fetch_state_e    r_state;
    logic [PC_W-1:0] r_fetch_pc;
    logic [CNT_W-1:0] r_live_out;
    logic [CNT_W-1:0] r_stale_out;

    logic [OCC_W-1:0] w_occ;
    fetch_entry_t     w_q_head;
    fetch_entry_t     w_q_push_data;
    logic [PC_W-1:0]  w_pcf_head;
    logic [CNT_W-1:0] w_pcf_occ;

    logic             w_issue;
    logic             w_accept;
    logic             w_inflight_any;
    logic             w_rsp_stale;
    logic             w_rsp_live;
    logic             w_pcf_bypass;
    logic             w_pcf_push;
    logic             w_pcf_pop;
    logic             w_pop;
    logic [PC_W-1:0]  w_rsp_pc;
    logic [CNT_W-1:0] w_live_after;
    logic [CNT_W-1:0] w_stale_after;
    logic [SUM_W-1:0] w_credit_sum;
    logic [SUM_W-1:0] w_inflight_sum;

    assign w_credit_sum   = SUM_W'(w_occ) + SUM_W'(r_live_out);
    assign w_inflight_sum = SUM_W'(r_live_out) + SUM_W'(r_stale_out);
    assign w_inflight_any = (r_live_out != '0) | (r_stale_out != '0);

    assign w_issue  = resetl & (r_state == FETCH) & ~redirect_valid
                    & (w_credit_sum < SUM_W'(DEPTH))
                    & (w_inflight_sum < SUM_W'(MAX_OUT));
    assign w_accept = w_issue & imem_req_ready;

    // Stale requests are always older than live ones, so they are retired first.
    // A live response may belong to a request accepted in this very cycle.
    assign w_rsp_stale  = imem_rsp_valid & (r_stale_out != '0);
    assign w_rsp_live   = imem_rsp_valid & (r_stale_out == '0) & ((r_live_out != '0) | w_accept);
    assign w_pcf_bypass = w_rsp_live & ~w_inflight_any;
    assign w_pcf_push   = w_accept & ~w_pcf_bypass;
    assign w_pcf_pop    = (w_rsp_stale | w_rsp_live) & ~w_pcf_bypass;
    assign w_rsp_pc     = w_pcf_bypass ? r_fetch_pc : w_pcf_head;

    assign w_pop = instr_valid & instr_ready;

    assign w_q_push_data.pc    = w_rsp_pc;
    assign w_q_push_data.instr = imem_rsp_data;

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk         (Clk),
        .rst_n       (resetl),
        .i_push      (w_rsp_live),
        .i_push_data (w_q_push_data),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_head      (w_q_head),
        .o_occ       (w_occ)
    );

    fetch_fifo #(
        .WIDTH (PC_W),
        .DEPTH (MAX_OUT)
    ) u_pc_fifo (
        .clk         (Clk),
        .rst_n       (resetl),
        .i_push      (w_pcf_push),
        .i_push_data (r_fetch_pc),
        .i_pop       (w_pcf_pop),
        .i_flush     (1'b0),
        .o_head      (w_pcf_head),
        .o_occ       (w_pcf_occ)
    );

    assign w_live_after  = r_live_out + CNT_W'(w_accept) - CNT_W'(w_rsp_live);
    assign w_stale_after = r_stale_out - CNT_W'(w_rsp_stale);

    always_ff @(posedge Clk or negedge resetl) begin
        if (!resetl) begin
            r_fetch_pc  <= startpc & PC_ALIGN_MASK[PC_W-1:0];
            r_live_out  <= '0;
            r_stale_out <= '0;
            r_state     <= FETCH;
        end else if (redirect_valid) begin
            r_fetch_pc  <= redirect_pc & PC_ALIGN_MASK[PC_W-1:0];
            r_live_out  <= '0;
            r_stale_out <= w_stale_after + w_live_after;
            r_state     <= FETCH;
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + PC_W'(INSTR_BYTES);
            end
            r_live_out  <= w_live_after;
            r_stale_out <= w_stale_after;
            case (r_state)
                FETCH:   if (halt_req) r_state <= HALTING;
                HALTING: if (!w_inflight_any) r_state <= HALTED;
                HALTED:  r_state <= HALTED;
                default: r_state <= FETCH;
            endcase
        end
    end

    assign imem_req_valid = w_issue;
    assign imem_req_addr  = r_fetch_pc;
    assign currentpc      = r_fetch_pc;
    assign instr_valid    = (w_occ != '0);
    assign instr_out      = w_q_head.instr;
    assign instr_pc       = w_q_head.pc;
    assign halted         = (r_state == HALTED);

    a_no_orphan_rsp: assert property (@(posedge Clk) disable iff (!resetl)
        imem_rsp_valid |-> (w_inflight_any | w_accept));
    a_inflight_bound: assert property (@(posedge Clk) disable iff (!resetl)
        w_inflight_sum <= SUM_W'(MAX_OUT));
    a_pc_fifo_tracks: assert property (@(posedge Clk) disable iff (!resetl)
        SUM_W'(w_pcf_occ) == w_inflight_sum);

endmodule
